spdif_tx_param: RTL and testbench
=================================

SPDIF_TX_PARAM -- requirements
Module: spdif_tx_param

Interface
REQ-001 Parameter WIDTH, default 24: audio sample width per channel, legal range 16..24.
REQ-002 Parameter UI_CLKS, default 16: clk cycles per biphase half-cell (UI); 16 at 98.304 MHz gives 48 kHz frames; legal range >= 2, even.
REQ-003 Parameter UNDERRUN_MODE, default 0: sample sent when a channel has no fresh data (0 = zero, 1 = repeat last accepted).
REQ-004 clk  input  1  sole clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 data_i  input  2*WIDTH  samples; [2*WIDTH-1:WIDTH] = channel A (left), [WIDTH-1:0] = channel B (right).
REQ-007 ack_i  input  2  one-cycle strobe; ack_i[1] loads channel A, ack_i[0] loads channel B, each from its data_i half.
REQ-008 pop_o  output  2  one-cycle request; pop_o[1] = channel A holding register free, pop_o[0] = channel B.
REQ-009 cs_i  input  40  channel-status bits 0..39 (bit 0 first); bits 40..191 transmitted as 0; same status on both channels.
REQ-010 spdif_o  output  1  biphase-mark encoded S/PDIF line.

Function
REQ-011 Timing: 1 subframe = 32 slots = 64 UI; 1 frame = A then B subframe; 1 block = 192 frames; frame counter 0..191, wraps 191->0.
REQ-012 Slots: 0-3 preamble; 4-27 audio LSB first, sample left-justified (MSB in slot 27, unused low slots 0); 28 V; 29 U = 0; 30 C = cs bit[frame] (0 for frame >= 40); 31 P = even parity over slots 4-31.
REQ-013 Preambles: B on channel A of frame 0, M on channel A of other frames, W on every channel B; UI patterns 11101000 (B), 11100010 (M), 11100100 (W) when the preceding line level is 0, bitwise inverted when it is 1.
REQ-014 Biphase mark for slots 4-31: line toggles at every slot start; toggles again at slot midpoint iff bit = 1.
REQ-015 spdif_o changes only on UI boundaries, exactly UI_CLKS cycles apart; registered output, no glitches.
REQ-016 Per channel: one holding register plus full flag; ack_i[ch] with flag clear loads data_i half and sets flag.
REQ-017 ack_i[ch] while flag set: ignored, holding register unchanged.
REQ-018 Subframe load: at the first clk of a channel's slot 0, the shift register takes the holding register if full (V = 0), else the underrun sample per UNDERRUN_MODE (V = 1); flag cleared either way.
REQ-019 pop_o[ch] pulses high for exactly one cycle, the cycle after that load.
REQ-020 Simultaneous ack_i[ch] and load in the same cycle: the load sees the register as empty (underrun); the ack is then accepted into the now-free register, and pop_o[ch] is still pulsed.
REQ-021 Repeat mode: "last accepted" = last value loaded via ack; zero before any ack since reset.
REQ-022 cs_i sampled into an internal 40-bit register at the load of frame 0, channel A; changes mid-block take effect at the next block.
REQ-023 Latency: a sample acked within its channel's pop window is transmitted in the next subframe of that channel.

Reset
REQ-024 While rst = 0: spdif_o = 0, pop_o = 00, flags cleared, last-sample registers = 0, frame counter = 0, UI/slot counters = 0, cs register = 0.
REQ-025 The first clk after rst rises starts frame 0 channel A slot 0 (preamble B, preceding level 0), with underrun data (V = 1).
REQ-026 pop_o = 11 for exactly one cycle, the cycle after rst rises.
REQ-027 Reset asserted mid-subframe aborts transmission at the next edge; no partial completion.

Verification
REQ-028 Reset release, no acks -> pop_o = 11 once; spdif_o begins 11101000 at UI granularity (16 clk/UI); V = 1 and audio slots 0 on both channels; P even.
REQ-029 WIDTH = 24; ack A = 0x000001, B = 0xABCDEF every frame -> decoded audio matches; V = 0; slot 8-27 pattern exact; B preamble every 192nd frame, M otherwise, W on every B subframe.
REQ-030 WIDTH = 16; A = 0x8001 -> slots 4-11 = 0, slot 12 = 1, slot 27 = 1.
REQ-031 UNDERRUN_MODE = 1; ack A = 0x123456 once, then stop -> following A subframes repeat 0x123456 with V = 1; mode 0 -> 0x000000 with V = 1.
REQ-032 Double ack on A before load -> second value dropped, first transmitted; ack coincident with load -> underrun subframe, acked value sent in the next A subframe.
REQ-033 cs_i = 0x00_0000_0005 held -> C slot = 1 in frames 0 and 2, 0 elsewhere; change cs_i mid-block -> no effect until frame 0 of the next block.

Source files
------------

// File: rtl/spdif_tx_param.sv
// S/PDIF (IEC 60958) transmitter: two-channel holding registers, subframe assembly
// with V/U/C/P bits, preamble insertion and biphase-mark line coding.
module spdif_tx_param #(
  parameter int WIDTH         = 24,
  parameter int UI_CLKS       = 16,
  parameter int UNDERRUN_MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] data_i,
  input  logic [1:0]         ack_i,
  output logic [1:0]         pop_o,
  input  logic [39:0]        cs_i,
  output logic               spdif_o
);

  localparam int CW = (UI_CLKS > 1) ? $clog2(UI_CLKS) : 1;
  localparam logic [CW-1:0] UI_LAST    = CW'(UI_CLKS - 1);
  localparam logic [7:0]    PRE_B      = 8'b11101000;
  localparam logic [7:0]    PRE_M      = 8'b11100010;
  localparam logic [7:0]    PRE_W      = 8'b11100100;
  localparam logic [7:0]    FRAME_LAST = 8'd191;

  // Enum value doubles as the ack_i/pop_o bit index of the channel.
  typedef enum logic {CH_B = 1'b0, CH_A = 1'b1} chan_t;

  logic [CW-1:0]    ui_cnt;
  logic [5:0]       ui_idx;
  chan_t            chan;
  logic [7:0]       frame;
  logic [WIDTH-1:0] hold [2];
  logic [WIDTH-1:0] last [2];
  logic [1:0]       full;
  logic [27:0]      shreg;
  logic             pre_inv;
  logic [39:0]      cs_reg;
  logic             started;

  logic             ui_start;
  logic             ui_end;
  logic             sf_end;
  logic             load;
  logic             ch_sel;
  logic [1:0]       load_mask;
  logic [WIDTH-1:0] smp;
  logic             v_bit;
  logic             c_bit;
  logic             p_bit;
  logic [23:0]      aud;
  logic [39:0]      cs_src;
  logic [7:0]       pre_pat;
  logic [27:0]      sf_word;

  // Subframe word: bit 0 is slot 4 (audio LSB), bits 24..27 are V, U, C, P.
  always_comb begin
    ui_start  = (ui_cnt == '0);
    ui_end    = (ui_cnt == UI_LAST);
    sf_end    = ui_end && (ui_idx == 6'd63);
    load      = ui_start && (ui_idx == 6'd0);
    ch_sel    = (chan == CH_A);
    load_mask = load ? (ch_sel ? 2'b10 : 2'b01) : 2'b00;
    smp       = '0;
    v_bit     = 1'b1;
    if (full[ch_sel]) begin
      smp   = hold[ch_sel];
      v_bit = 1'b0;
    end else if (UNDERRUN_MODE == 1) begin
      smp = last[ch_sel];
    end
    // Frame 0 channel A latches a new status block, so it must see cs_i directly.
    cs_src  = ((frame == 8'd0) && ch_sel) ? cs_i : cs_reg;
    c_bit   = (frame < 8'd40) ? cs_src[frame[5:0]] : 1'b0;
    aud     = 24'(smp) << (24 - WIDTH);
    p_bit   = ^{aud, v_bit, c_bit};
    sf_word = {p_bit, c_bit, 1'b0, v_bit, aud};
    pre_pat = !ch_sel ? PRE_W : ((frame == 8'd0) ? PRE_B : PRE_M);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ui_cnt  <= '0;
      ui_idx  <= '0;
      chan    <= CH_A;
      frame   <= '0;
      full    <= '0;
      hold[0] <= '0;
      hold[1] <= '0;
      last[0] <= '0;
      last[1] <= '0;
      shreg   <= '0;
      pre_inv <= 1'b0;
      cs_reg  <= '0;
      started <= 1'b0;
      pop_o   <= '0;
      spdif_o <= 1'b0;
    end else begin
      started <= 1'b1;
      pop_o   <= load_mask | {2{~started}};
      ui_cnt  <= ui_end ? '0 : ui_cnt + 1'b1;
      if (ui_end)
        ui_idx <= ui_idx + 6'd1;
      if (sf_end) begin
        chan <= ch_sel ? CH_B : CH_A;
        if (!ch_sel)
          frame <= (frame == FRAME_LAST) ? '0 : frame + 8'd1;
      end

      // Preamble UIs are relative to the level left by the previous subframe.
      if (ui_start) begin
        if (ui_idx == 6'd0) begin
          spdif_o <= pre_pat[7] ^ spdif_o;
          pre_inv <= spdif_o;
          shreg   <= sf_word;
          if (ch_sel && (frame == 8'd0))
            cs_reg <= cs_i;
        end else if (ui_idx < 6'd8) begin
          spdif_o <= pre_pat[3'd7 - ui_idx[2:0]] ^ pre_inv;
        end else if (!ui_idx[0]) begin
          spdif_o <= ~spdif_o;
        end else begin
          spdif_o <= spdif_o ^ shreg[0];
          shreg   <= shreg >> 1;
        end
      end

      // A load frees the register first, so a coincident ack is still accepted.
      for (int ch = 0; ch < 2; ch++) begin
        if (load_mask[ch])
          full[ch] <= 1'b0;
        if (ack_i[ch] && (!full[ch] || load_mask[ch])) begin
          hold[ch] <= data_i[ch*WIDTH +: WIDTH];
          last[ch] <= data_i[ch*WIDTH +: WIDTH];
          full[ch] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spdif_tx_param.sv
// Directed self-checking bench for spdif_tx_param: four instances with different
// parameters, line recording and biphase-mark decoding of transmitted subframes.
module tb_spdif_tx_param;

  localparam int NUI = 25000;
  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  logic        clk;
  logic        rst;
  logic [47:0] data0, data1, data2;
  logic [31:0] data3;
  logic [1:0]  ack0, ack1, ack2, ack3;
  logic [1:0]  pop0, pop1, pop2, pop3;
  logic [39:0] cs0, cs1, cs2, cs3;
  logic        s0, s1, s2, s3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit line0 [NUI];
  bit line1 [NUI];
  bit line3 [NUI];

  logic [23:0] u1_aud [8] = '{24'h0, 24'h123456, 24'h123456, 24'h123456,
                              24'h111111, 24'h111111, 24'h333333, 24'h333333};
  bit          u1_v   [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  spdif_tx_param #(.WIDTH(24), .UI_CLKS(2), .UNDERRUN_MODE(0)) u0 (
    .clk(clk), .rst(rst), .data_i(data0), .ack_i(ack0), .pop_o(pop0),
    .cs_i(cs0), .spdif_o(s0));
  spdif_tx_param #(.WIDTH(24), .UI_CLKS(2), .UNDERRUN_MODE(1)) u1 (
    .clk(clk), .rst(rst), .data_i(data1), .ack_i(ack1), .pop_o(pop1),
    .cs_i(cs1), .spdif_o(s1));
  spdif_tx_param u2 (
    .clk(clk), .rst(rst), .data_i(data2), .ack_i(ack2), .pop_o(pop2),
    .cs_i(cs2), .spdif_o(s2));
  spdif_tx_param #(.WIDTH(16), .UI_CLKS(2), .UNDERRUN_MODE(0)) u3 (
    .clk(clk), .rst(rst), .data_i(data3), .ack_i(ack3), .pop_o(pop3),
    .cs_i(cs3), .spdif_o(s3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc = number of active edges since reset release; UI g of a 2-clk instance
  // is visible at the negedge where cyc == 2g+1.
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst && cyc >= 1 && ((cyc - 1) % 2) == 0 && ((cyc - 1) / 2) < NUI) begin
      line0[(cyc - 1) / 2] = s0;
      line1[(cyc - 1) / 2] = s1;
      line3[(cyc - 1) / 2] = s3;
    end
  end

  task automatic check_output(input string tag, input logic [47:0] obs,
                              input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advances to the negedge where cyc == c, dropping one-cycle acks on the way.
  task automatic apply_stimulus(input int c);
    while (cyc < c) begin
      @(negedge clk);
      ack0 = 2'b00;
      ack1 = 2'b00;
      ack3 = 2'b00;
    end
  endtask

  function automatic bit get_ui(input int inst, input int g);
    case (inst)
      0:       return line0[g];
      1:       return line1[g];
      default: return line3[g];
    endcase
  endfunction

  task automatic decode_sf(input int inst, input int n, output logic [7:0] pre,
                           output logic [27:0] word, output bit bad);
    int base;
    bit prev, a, b, c;
    base = n * 64;
    prev = (n == 0) ? 1'b0 : get_ui(inst, base - 1);
    bad  = 1'b0;
    for (int k = 0; k < 8; k++)
      pre[7-k] = get_ui(inst, base + k) ^ prev;
    for (int s = 4; s < 32; s++) begin
      a = get_ui(inst, base + 2*s - 1);
      b = get_ui(inst, base + 2*s);
      c = get_ui(inst, base + 2*s + 1);
      if (a == b) bad = 1'b1;
      word[s-4] = b ^ c;
    end
  endtask

  function automatic logic [27:0] exp_word(input logic [23:0] aud, input bit v,
                                           input bit c);
    return {^{aud, v, c}, c, 1'b0, v, aud};
  endfunction

  task automatic check_sf(input int inst, input int n, input logic [7:0] epre,
                          input logic [27:0] eword, input string tag);
    logic [7:0]  pre;
    logic [27:0] word;
    bit          bad;
    decode_sf(inst, n, pre, word, bad);
    check_output({tag, "_pre"}, 48'(pre), 48'(epre));
    check_output({tag, "_word"}, 48'(word), 48'(eword));
    check_output({tag, "_biphase"}, 48'(bad), 48'(0));
  endtask

  initial begin
    logic [7:0]  pat;
    logic [39:0] csb;
    logic [23:0] ea, eb;
    bit          ev, ec;
    int          fb;

    rst   = 1'b0;
    ack0  = 2'b00; ack1 = 2'b00; ack2 = 2'b00; ack3 = 2'b00;
    data0 = {24'h000001, 24'hABCDEF};
    data1 = '0;
    data2 = '0;
    data3 = '0;
    cs0   = 40'h00_0000_0005;
    cs1   = '0; cs2 = '0; cs3 = '0;

    repeat (4) @(negedge clk);
    check_output("rst_line_u0", 48'(s0), 48'(0));
    check_output("rst_line_u2", 48'(s2), 48'(0));
    check_output("rst_pop_u0", 48'(pop0), 48'(0));
    check_output("rst_pop_u2", 48'(pop2), 48'(0));
    rst = 1'b1;

    // Default-parameter instance: preamble B at 16 clocks per UI, every cycle.
    pat = PRE_B;
    for (int g = 0; g < 8; g++) begin
      for (int k = 0; k < 16; k++) begin
        apply_stimulus(16*g + 1 + k);
        check_output($sformatf("u2_ui%0d_c%0d", g, k), 48'(s2), 48'(pat[7-g]));
        if (cyc == 1) begin
          check_output("pop_first_u0", 48'(pop0), 48'(2'b11));
          check_output("pop_first_u1", 48'(pop1), 48'(2'b11));
          check_output("pop_first_u2", 48'(pop2), 48'(2'b11));
        end
        if (cyc == 2) begin
          check_output("pop_second_u0", 48'(pop0), 48'(2'b00));
          check_output("pop_second_u2", 48'(pop2), 48'(2'b00));
        end
      end
    end

    for (int f = 1; f <= 193; f++) begin
      apply_stimulus((2*f - 1)*128 + 2);
      ack0 = 2'b10;
      if (f == 1) begin
        data1 = {24'h123456, 24'h0};  ack1 = 2'b10;
        data3 = {16'h8001, 16'h0};    ack3 = 2'b10;
      end
      apply_stimulus((2*f - 1)*128 + 3);
      ack0 = 2'b01;
      if (f == 4) begin
        apply_stimulus(900);
        data1 = {24'h111111, 24'h0};  ack1 = 2'b10;
        apply_stimulus(902);
        data1 = {24'h222222, 24'h0};  ack1 = 2'b10;
      end
      if (f == 5) begin
        apply_stimulus(1280);
        data1 = {24'h333333, 24'h0};  ack1 = 2'b10;
        apply_stimulus(1281);
        check_output("pop_coincident_u1", 48'(pop1), 48'(2'b10));
        apply_stimulus(1282);
        check_output("pop_once_u1", 48'(pop1), 48'(2'b00));
      end
      if (f == 10)
        cs0 = 40'h00_0000_1002;
    end
    apply_stimulus(49930);

    for (int f = 0; f <= 194; f++) begin
      fb  = f % 192;
      csb = (f < 192) ? 40'h00_0000_0005 : 40'h00_0000_1002;
      ec  = (fb < 40) ? csb[fb] : 1'b0;
      if (f == 0 || f == 194) begin
        ea = 24'h0; eb = 24'h0; ev = 1'b1;
      end else begin
        ea = 24'h000001; eb = 24'hABCDEF; ev = 1'b0;
      end
      check_sf(0, 2*f, (fb == 0) ? PRE_B : PRE_M, exp_word(ea, ev, ec),
               $sformatf("u0_f%0d_A", f));
      check_sf(0, 2*f + 1, PRE_W, exp_word(eb, ev, ec),
               $sformatf("u0_f%0d_B", f));
    end

    for (int f = 0; f < 8; f++)
      check_sf(1, 2*f, (f == 0) ? PRE_B : PRE_M, exp_word(u1_aud[f], u1_v[f], 1'b0),
               $sformatf("u1_f%0d_A", f));
    check_sf(1, 1, PRE_W, exp_word(24'h0, 1'b1, 1'b0), "u1_f0_B");
    check_sf(1, 3, PRE_W, exp_word(24'h0, 1'b1, 1'b0), "u1_f1_B");

    check_sf(3, 0, PRE_B, exp_word(24'h0, 1'b1, 1'b0), "u3_f0_A");
    check_sf(3, 2, PRE_M, exp_word(24'h800100, 1'b0, 1'b0), "u3_f1_A");
    check_sf(3, 4, PRE_M, exp_word(24'h0, 1'b1, 1'b0), "u3_f2_A");

    // Reset in the middle of a subframe must silence the line at the next edge.
    rst = 1'b0;
    @(negedge clk);
    check_output("midrst_line_u0", 48'(s0), 48'(0));
    check_output("midrst_line_u1", 48'(s1), 48'(0));
    check_output("midrst_line_u2", 48'(s2), 48'(0));
    check_output("midrst_line_u3", 48'(s3), 48'(0));
    check_output("midrst_pop_u0", 48'(pop0), 48'(0));
    rst = 1'b1;
    @(negedge clk);
    check_output("rerelease_pop_u0", 48'(pop0), 48'(2'b11));
    check_output("rerelease_line_u0", 48'(s0), 48'(1));
    @(negedge clk);
    check_output("rerelease_pop2_u0", 48'(pop0), 48'(2'b00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
